fifo_rd_drain: RTL and testbench
================================

FIFO_RD_DRAIN -- requirements
Module: fifo_rd_drain

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of FIFO read data and output stream data.
REQ-002 Parameter: CNT_WIDTH, default 16, width of the transfer counter.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 Port: enable  input  1  when high, block may issue new FIFO reads.
REQ-006 Port: fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 Port: fifo_data  input  DATA_WIDTH  upstream FIFO registered read data, valid the cycle after a read strobe.
REQ-008 Port: fifo_rd  output  1  read strobe to upstream FIFO, one pop per cycle high.
REQ-009 Port: m_valid  output  1  output stream word valid.
REQ-010 Port: m_data  output  DATA_WIDTH  output stream word.
REQ-011 Port: m_ready  input  1  downstream accepts word when high with m_valid.
REQ-012 Port: xfer_count  output  CNT_WIDTH  number of words accepted downstream since reset.
REQ-013 Port: ovf_err  output  1  sticky error, capture attempted into a full buffer.

Function
REQ-014 Block SHALL hold a 2-entry in-order output buffer (head/tail pointers, occupancy occ in 0..2) and a 1-bit rd_pending register equal to fifo_rd delayed one cycle.
REQ-015 pop SHALL be defined as m_valid & m_ready in the same cycle.
REQ-016 fifo_rd SHALL be combinational: enable & !fifo_empty & ((occ + rd_pending - pop) < 2), evaluated at width >= 3 bits with no wrap.
REQ-017 fifo_rd SHALL never be high while rst is high.
REQ-018 When rd_pending is high, fifo_data SHALL be written to the buffer tail at that clock edge and occ incremented.
REQ-019 Latency: fifo_rd high in cycle N SHALL give fifo_data captured at end of cycle N+1 and m_valid high no later than cycle N+2.
REQ-020 m_valid SHALL equal (occ != 0); m_data SHALL equal the buffer head entry.
REQ-021 While m_valid is high and m_ready low, m_valid and m_data SHALL hold unchanged.
REQ-022 Capture and pop in the same cycle SHALL leave occ unchanged and preserve word order.
REQ-023 With enable high, FIFO never empty and m_ready held high, block SHALL sustain one word per cycle after the initial 2-cycle latency.
REQ-024 Deasserting enable SHALL stop new reads only; a pending read SHALL still be captured and buffered words still delivered.
REQ-025 Words SHALL leave m_data in exactly the order fifo_rd was issued; no word dropped or duplicated.
REQ-026 xfer_count SHALL increment by 1 on each pop and wrap from all-ones to 0.
REQ-027 If a capture occurs with occ == 2 and no pop, ovf_err SHALL set and remain set until reset; the word SHALL be discarded (unreachable by construction, asserted in verification).

Reset
REQ-028 With rst high at a clock edge: occ=0, head=tail=0, rd_pending=0, m_valid=0, m_data=0, xfer_count=0, ovf_err=0.
REQ-029 Reset asserted mid-operation SHALL discard all buffered and pending words; FIFO data returned the cycle after reset for a pre-reset read SHALL be ignored.
REQ-030 First fifo_rd after reset SHALL not occur before the first edge with rst low.

Verification
REQ-031 Reset: hold rst 2 cycles with fifo_empty=0, enable=1 -> fifo_rd=0, m_valid=0, m_data=0, xfer_count=0, ovf_err=0 throughout.
REQ-032 Single word: FIFO holds 0xA5, enable=1, m_ready=1 -> fifo_rd one cycle at N, m_valid=1 with m_data=0xA5 at N+2 for one cycle, xfer_count=1.
REQ-033 Back-pressure: FIFO holds 0x01..0x05, m_ready=0 -> exactly 2 fifo_rd pulses, m_data=0x01 held; raise m_ready -> 0x01..0x05 delivered in order, xfer_count=5, ovf_err=0.
REQ-034 Streaming: 16 words 0x00..0x0F, m_ready=1 -> fifo_rd high 16 consecutive cycles, m_valid high 16 consecutive cycles, in order.
REQ-035 Enable drop: deassert enable in cycle after a fifo_rd -> no further fifo_rd, pending word still delivered; re-enable resumes from next FIFO word.
REQ-036 Counter wrap: CNT_WIDTH=4, deliver 17 words -> xfer_count reads 1; reset mid-stream with 2 words buffered -> m_valid=0 next cycle, no stale word appears.

Source files
------------

// File: rtl/fifo_rd_drain.sv
// Drains an upstream FIFO with registered read data into a valid/ready output
// stream through a 2-entry in-order skid buffer, counting delivered words.
`timescale 1ns/1ps

module fifo_rd_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  xfer_count,
    output logic                  ovf_err
);

    // Output handshake: a word transfers on any rising edge where m_valid and
    // m_ready are both high; once m_valid rises, m_valid and m_data stay
    // stable until that transfer happens.

    logic [DATA_WIDTH-1:0] buf_mem [2];
    logic                  head;
    logic                  tail;
    logic [1:0]            occ;
    logic                  rd_pending;

    logic                  pop;
    logic [2:0]            credit;
    logic                  cap_ok;
    logic                  cap_drop;
    logic [1:0]            occ_next;

    assign pop = m_valid & m_ready;

    // Slots already claimed: buffered words plus the read in flight, minus the
    // word leaving this cycle. Three bits so the sum never wraps.
    assign credit = {1'b0, occ} + {2'b00, rd_pending} - {2'b00, pop};

    assign fifo_rd = !rst && enable && !fifo_empty && (credit < 3'd2);

    assign m_valid = (occ != 2'd0);
    assign m_data  = buf_mem[head];

    // A capture into a full buffer is only legal when the head leaves in the
    // same cycle; otherwise the word is dropped and flagged.
    always_comb begin
        cap_ok   = 1'b0;
        cap_drop = 1'b0;
        if (rd_pending) begin
            if ((occ == 2'd2) && !pop) begin
                cap_drop = 1'b1;
            end else begin
                cap_ok = 1'b1;
            end
        end
    end

    always_comb begin
        occ_next = occ;
        if (cap_ok && !pop) begin
            occ_next = occ + 2'd1;
        end else if (!cap_ok && pop) begin
            occ_next = occ - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            head       <= 1'b0;
            tail       <= 1'b0;
            occ        <= 2'd0;
            rd_pending <= 1'b0;
            xfer_count <= '0;
            ovf_err    <= 1'b0;
        end else begin
            rd_pending <= fifo_rd;
            occ        <= occ_next;
            if (cap_ok) begin
                buf_mem[tail] <= fifo_data;
                tail          <= ~tail;
            end
            if (pop) begin
                head       <= ~head;
                xfer_count <= xfer_count + CNT_WIDTH'(1);
            end
            if (cap_drop) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain: an upstream FIFO model with registered read
// data feeds two instances (16-bit and 4-bit transfer counters).
`timescale 1ns/1ps

module tb_fifo_rd_drain;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic [15:0] xfer_count;
    logic       ovf_err;

    logic       fifo_rd4;
    logic       m_valid4;
    logic [7:0] m_data4;
    logic [3:0] xfer_count4;
    logic       ovf_err4;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fq [0:511];
    int rd_idx = 0;
    int wr_idx = 0;

    fifo_rd_drain #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd(fifo_rd), .m_valid(m_valid),
        .m_data(m_data), .m_ready(m_ready), .xfer_count(xfer_count),
        .ovf_err(ovf_err)
    );

    fifo_rd_drain #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd(fifo_rd4), .m_valid(m_valid4),
        .m_data(m_data4), .m_ready(m_ready), .xfer_count(xfer_count4),
        .ovf_err(ovf_err4)
    );

    // ---- clock / upstream FIFO model ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = (rd_idx >= wr_idx);

    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_data <= fq[rd_idx];
            rd_idx    <= rd_idx + 1;
        end
    end

    // ---- driver tasks ----
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        fq[wr_idx] = w;
        wr_idx = wr_idx + 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        m_ready = 1'b0;
        cyc();
        wr_idx = rd_idx;
        cyc();
        rst = 1'b0;
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        m_ready = 1'b0;
        push(8'h11);
        for (int i = 0; i < 2; i++) begin
            cyc();
            settle();
            n_checks++; if (fifo_rd !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_rd: got %b want 0", fifo_rd); end
            n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
            n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %h want 00", m_data); end
            n_checks++; if (xfer_count !== 16'd0) begin n_fail++; $display("FAIL reset_xfer_count: got %0d want 0", xfer_count); end
            n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf_err: got %b want 0", ovf_err); end
            n_checks++; if (xfer_count4 !== 4'd0) begin n_fail++; $display("FAIL reset_xfer_count4: got %0d want 0", xfer_count4); end
        end
    endtask

    task automatic test_single();
        do_reset();
        enable = 1'b1;
        m_ready = 1'b1;
        push(8'hA5);
        settle();
        n_checks++; if (fifo_rd !== 1'b1) begin n_fail++; $display("FAIL single_rd_n: got %b want 1", fifo_rd); end
        cyc(); settle();
        n_checks++; if (fifo_rd !== 1'b0) begin n_fail++; $display("FAIL single_rd_n1: got %b want 0", fifo_rd); end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_n1: got %b want 0", m_valid); end
        cyc(); settle();
        n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_n2: got %b want 1", m_valid); end
        n_checks++; if (m_data !== 8'hA5) begin n_fail++; $display("FAIL single_data_n2: got %h want a5", m_data); end
        cyc(); settle();
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_n3: got %b want 0", m_valid); end
        n_checks++; if (xfer_count !== 16'd1) begin n_fail++; $display("FAIL single_xfer_count: got %0d want 1", xfer_count); end
    endtask

    task automatic test_backpressure();
        int pulses;
        int k;
        do_reset();
        for (int i = 1; i <= 5; i++) push(8'(i));
        enable = 1'b1;
        m_ready = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            settle();
            if (fifo_rd) pulses++;
            if (c >= 2) begin
                n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid c%0d: got %b want 1", c, m_valid); end
                n_checks++; if (m_data !== 8'h01) begin n_fail++; $display("FAIL bp_hold_data c%0d: got %h want 01", c, m_data); end
            end
            cyc();
        end
        n_checks++; if (pulses !== 2) begin n_fail++; $display("FAIL bp_rd_pulses: got %0d want 2", pulses); end
        m_ready = 1'b1;
        k = 1;
        for (int c = 0; c < 20 && k <= 5; c++) begin
            settle();
            if (m_valid) begin
                n_checks++; if (m_data !== 8'(k)) begin n_fail++; $display("FAIL bp_order: got %h want %h", m_data, 8'(k)); end
                k++;
            end
            cyc();
        end
        settle();
        n_checks++; if (k !== 6) begin n_fail++; $display("FAIL bp_delivered: got %0d want 5", k - 1); end
        n_checks++; if (xfer_count !== 16'd5) begin n_fail++; $display("FAIL bp_xfer_count: got %0d want 5", xfer_count); end
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL bp_ovf_err: got %b want 0", ovf_err); end
    endtask

    task automatic test_streaming();
        do_reset();
        for (int i = 0; i < 16; i++) push(8'(i));
        enable = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            settle();
            n_checks++; if (fifo_rd !== (c < 16)) begin n_fail++; $display("FAIL stream_rd c%0d: got %b want %b", c, fifo_rd, (c < 16)); end
            n_checks++; if (m_valid !== (c >= 2 && c < 18)) begin n_fail++; $display("FAIL stream_valid c%0d: got %b want %b", c, m_valid, (c >= 2 && c < 18)); end
            if (c >= 2 && c < 18) begin
                n_checks++; if (m_data !== 8'(c - 2)) begin n_fail++; $display("FAIL stream_data c%0d: got %h want %h", c, m_data, 8'(c - 2)); end
            end
            cyc();
        end
        n_checks++; if (xfer_count !== 16'd16) begin n_fail++; $display("FAIL stream_xfer_count: got %0d want 16", xfer_count); end
    endtask

    task automatic test_enable_drop();
        int k;
        do_reset();
        for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
        enable = 1'b1;
        m_ready = 1'b1;
        settle();
        n_checks++; if (fifo_rd !== 1'b1) begin n_fail++; $display("FAIL endrop_first_rd: got %b want 1", fifo_rd); end
        cyc();
        enable = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            settle();
            n_checks++; if (fifo_rd !== 1'b0) begin n_fail++; $display("FAIL endrop_no_rd c%0d: got %b want 0", c, fifo_rd); end
            n_checks++; if (m_valid !== (c == 2)) begin n_fail++; $display("FAIL endrop_valid c%0d: got %b want %b", c, m_valid, (c == 2)); end
            if (c == 2) begin
                n_checks++; if (m_data !== 8'h30) begin n_fail++; $display("FAIL endrop_pending_data: got %h want 30", m_data); end
            end
            cyc();
        end
        enable = 1'b1;
        settle();
        n_checks++; if (fifo_rd !== 1'b1) begin n_fail++; $display("FAIL endrop_resume_rd: got %b want 1", fifo_rd); end
        k = 'h31;
        for (int c = 0; c < 20 && k <= 'h35; c++) begin
            settle();
            if (m_valid) begin
                n_checks++; if (m_data !== 8'(k)) begin n_fail++; $display("FAIL endrop_order: got %h want %h", m_data, 8'(k)); end
                k++;
            end
            cyc();
        end
        settle();
        n_checks++; if (k !== 'h36) begin n_fail++; $display("FAIL endrop_delivered: got %0d want 5", k - 'h31); end
        n_checks++; if (xfer_count !== 16'd6) begin n_fail++; $display("FAIL endrop_xfer_count: got %0d want 6", xfer_count); end
    endtask

    task automatic test_counter_wrap();
        int cnt;
        do_reset();
        for (int i = 0; i < 17; i++) push(8'h40 + 8'(i));
        enable = 1'b1;
        m_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 40 && cnt < 17; c++) begin
            settle();
            if (m_valid) begin
                n_checks++; if (m_data !== 8'h40 + 8'(cnt)) begin n_fail++; $display("FAIL wrap_order: got %h want %h", m_data, 8'h40 + 8'(cnt)); end
                cnt++;
            end
            cyc();
        end
        settle();
        n_checks++; if (cnt !== 17) begin n_fail++; $display("FAIL wrap_delivered: got %0d want 17", cnt); end
        n_checks++; if (xfer_count !== 16'd17) begin n_fail++; $display("FAIL wrap_xfer_count16: got %0d want 17", xfer_count); end
        n_checks++; if (xfer_count4 !== 4'd1) begin n_fail++; $display("FAIL wrap_xfer_count4: got %0d want 1", xfer_count4); end
        n_checks++; if (ovf_err4 !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf_err4: got %b want 0", ovf_err4); end
    endtask

    task automatic test_reset_midstream();
        int k;
        do_reset();
        for (int i = 0; i < 8; i++) push(8'h50 + 8'(i));
        enable = 1'b1;
        m_ready = 1'b0;
        cyc(); cyc(); cyc();
        settle();
        n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL mid_full_valid: got %b want 1", m_valid); end
        n_checks++; if (m_data !== 8'h50) begin n_fail++; $display("FAIL mid_full_data: got %h want 50", m_data); end
        n_checks++; if (fifo_rd !== 1'b0) begin n_fail++; $display("FAIL mid_full_no_rd: got %b want 0", fifo_rd); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m_ready = 1'b1;
        settle();
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after_rst_valid: got %b want 0", m_valid); end
        n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL mid_after_rst_data: got %h want 00", m_data); end
        n_checks++; if (xfer_count !== 16'd0) begin n_fail++; $display("FAIL mid_after_rst_count: got %0d want 0", xfer_count); end
        n_checks++; if (fifo_rd !== 1'b1) begin n_fail++; $display("FAIL mid_after_rst_rd: got %b want 1", fifo_rd); end
        k = 'h52;
        for (int c = 0; c < 20 && k <= 'h57; c++) begin
            settle();
            if (m_valid) begin
                n_checks++; if (m_data !== 8'(k)) begin n_fail++; $display("FAIL mid_order: got %h want %h", m_data, 8'(k)); end
                k++;
            end
            cyc();
        end
        settle();
        n_checks++; if (k !== 'h58) begin n_fail++; $display("FAIL mid_delivered: got %0d want 6", k - 'h52); end
        n_checks++; if (xfer_count !== 16'd6) begin n_fail++; $display("FAIL mid_xfer_count: got %0d want 6", xfer_count); end
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL mid_ovf_err: got %b want 0", ovf_err); end
    endtask

    // ---- sequence and final report ----
    initial begin
        rst = 1'b1;
        enable = 1'b0;
        m_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_enable_drop();
        test_counter_wrap();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
